cic_rate_ctrl: RTL

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

---
 rtl/cic_rate_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cic_rate_ctrl.sv
// Rate and flush controller for a CIC interpolator: generates input/output strobes,
// buffers upstream samples in a 2-entry FIFO and counts starved input strobes.
module cic_rate_ctrl #(
    parameter int ISZ       = 16,
    parameter int DIV_W     = 16,
    parameter int RAT_W     = 8,
    parameter int FLUSH_CYC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [RAT_W-1:0]      cfg_ratio,
    input  logic                  cfg_load,
    input  logic signed [ISZ-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic signed [ISZ-1:0] cic_in,
    output logic                  cic_in_rate,
    output logic                  cic_out_rate,
    output logic                  cic_reset,
    output logic [15:0]           underrun_cnt,
    output logic                  busy
);
    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   flush_cnt;
    logic [DIV_W-1:0]  div_lat, div_cnt;
    logic [RAT_W-1:0]  rat_lat, phase;
    logic signed [ISZ-1:0] mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count, count_nxt;
    logic              wrap, in_stb, push, pop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // enable=0 wins over everything, including a pending cfg_load
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = FLUSH;
                FLUSH:   if (!cfg_load && flush_cnt == FC_W'(FLUSH_CYC - 1)) state_nxt = RUN;
                RUN:     if (cfg_load) state_nxt = FLUSH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign wrap   = (state == RUN) && (state_nxt == RUN) && (div_cnt == div_lat);
    assign in_stb = wrap && (phase == '0);
    assign push   = s_valid && s_ready && (state == RUN);
    assign pop    = in_stb && (count != 2'd0);

    always_comb begin
        count_nxt = count;
        if (state_nxt != RUN) count_nxt = 2'd0;
        else if (push && !pop) count_nxt = count + 2'd1;
        else if (pop && !push) count_nxt = count - 2'd1;
    end

    // control: flush timer, latched config, divider, phase, FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            div_lat   <= '0;
            rat_lat   <= '0;
            div_cnt   <= '0;
            phase     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (cfg_load || (state == IDLE && enable)) begin
                div_lat <= cfg_div;
                rat_lat <= cfg_ratio;
            end
            if (state_nxt == FLUSH && (state != FLUSH || cfg_load)) flush_cnt <= '0;
            else if (state == FLUSH)                                flush_cnt <= flush_cnt + 1'b1;
            if (state != RUN || state_nxt != RUN) begin
                div_cnt <= '0;
                phase   <= '0;
            end else begin
                div_cnt <= wrap ? '0 : div_cnt + 1'b1;
                if (wrap) phase <= (phase == rat_lat) ? '0 : phase + 1'b1;
            end
            if (state_nxt != RUN) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // registered outputs, aligned with the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            cic_reset    <= 1'b1;
            busy         <= 1'b0;
            s_ready      <= 1'b0;
            cic_out_rate <= 1'b0;
            cic_in_rate  <= 1'b0;
            cic_in       <= '0;
            underrun_cnt <= 16'd0;
        end else begin
            cic_reset    <= (state_nxt != RUN);
            busy         <= (state_nxt == RUN);
            s_ready      <= (state_nxt == RUN) && (count_nxt != 2'd2);
            cic_out_rate <= wrap;
            cic_in_rate  <= in_stb;
            if (in_stb) begin
                cic_in <= pop ? mem[rd_ptr] : '0;
                if (!pop) underrun_cnt <= sat_inc(underrun_cnt);
            end
        end
    end
endmodule
